iob_sipo_deser: RTL and testbench
=================================

// Module: iob_sipo_deser
// PURPOSE
//  Parametrised serial-to-parallel deserializer with word framing and output handshake. Accepts
//  LANES bits per beat under s_valid_i, assembles DATA_W-bit words and presents each word on a
//  registered valid/ready output port. Adds bit ordering, resync and overrun detection over a
//  plain shift register. Sits between serial PHY/bit-bang front ends and word-wide datapaths.
// PARAMETERS
//  DATA_W     32  parallel word width; must be a multiple of LANES
//  LANES      1   serial bits accepted per beat (1,2,4,8)
//  MSB_FIRST  1   1: first beat lands in the word's MSBs; 0: first beat lands in its LSBs
// PORTS
//  clk_i      in   1                  clock, all logic on rising edge
//  cke_i      in   1                  clock enable; 0 freezes all state (outputs held)
//  rst_n_i    in   1                  reset, synchronous, active-low
//  s_valid_i  in   1                  serial beat valid
//  s_i        in   LANES              serial beat data
//  sof_i      in   1                  start-of-word; qualified by s_valid_i
//  p_o        out  DATA_W             assembled word
//  p_valid_o  out  1                  p_o holds an unconsumed word
//  p_ready_i  in   1                  consumer accepts p_o when p_valid_o & p_ready_i
//  beat_cnt_o out  CNT_W              beats collected for the word in progress
//  overrun_o  out  1                  sticky: a completed word was dropped
//  resync_o   out  1                  sticky: sof_i discarded a partial word
//  clr_i      in   1                  clears overrun_o and resync_o
// BEHAVIOUR
//  - Reset (rst_n_i=0 at a rising edge with cke_i=1): shift reg, p_o, beat_cnt_o = 0;
//    p_valid_o, overrun_o, resync_o = 0. Reset has priority over every input.
//  - BEATS = DATA_W/LANES, CNT_W = max(1,$clog2(BEATS)). Beat accepted iff cke_i & s_valid_i.
//  - MSB_FIRST=1: sr <= {sr[DATA_W-LANES-1:0], s_i}; s_i[LANES-1] is the MSB within a beat.
//    MSB_FIRST=0: sr <= {s_i, sr[DATA_W-1:LANES]}; s_i[0] is the LSB within a beat.
//  - beat_cnt_o increments per accepted beat, wraps BEATS-1 -> 0 on the completing beat.
//  - Completing beat: next-sr value (including current s_i) loads p_o; p_valid_o=1 next cycle.
//    Latency: last beat edge -> p_valid_o high after that same edge (1 cycle registered).
//  - Output slot: load allowed if !p_valid_o, or p_valid_o & p_ready_i same cycle (back-to-back,
//    p_valid_o stays 1). Otherwise word dropped, p_o unchanged, overrun_o <= 1.
//  - Consume without new load: p_valid_o & p_ready_i -> p_valid_o <= 0. p_o held until reload.
//  - sof_i & s_valid_i: current beat is beat 0 (beat_cnt_o <= 1, or word completes if BEATS=1);
//    if beat_cnt_o != 0 at that time, partial word discarded, resync_o <= 1.
//  - sof_i without s_valid_i ignored. s_i ignored when s_valid_i=0.
//  - clr_i & new sticky event same cycle: event wins (flag stays/sets 1).
//  - Mid-word reset: partial word and pending p_o lost; no flags set.
// STRUCTURE
//  - Shared include iob_sipo_deser_defs.vh: BEATS, CNT_W localparams and ordering constants.
//  - Datapath: sr and p_o via iob_reg-family registers with sync reset and enable.
//  - One sub-module: iob_modcnt (modulo-BEATS counter, sync load for sof_i) for beat_cnt_o.
//  - Elaboration check: DATA_W % LANES != 0 or LANES > DATA_W -> $error.
// TESTING
//  1 DATA_W=8,LANES=1,MSB_FIRST=1: bits 1,0,1,0,0,1,0,1, p_ready_i=1 -> p_o=0xA5, p_valid_o 1 cycle
//  2 Same bits, MSB_FIRST=0 -> p_o=0xA5 reversed = 0xA5? no: LSB first gives p_o=0xA5 bit-reversed 0xA5;
//    use 1,1,0,0,0,0,0,0 -> MSB_FIRST=1 p_o=0xC0, MSB_FIRST=0 p_o=0x03
//  3 DATA_W=32,LANES=4: nibbles 1..8 continuous, p_ready_i=1 -> p_o=0x12345678, beat_cnt_o 0 after
//  4 p_ready_i=0, two full words 0x11,0x22 (DATA_W=8) -> p_o=0x11, overrun_o=1; clr_i -> 0
//  5 3 beats then sof_i&s_valid_i -> resync_o=1, beat_cnt_o=1, next word assembled from new beat 0
//  6 rst_n_i=0 mid-word with p_valid_o=1 -> next cycle all outputs 0; cke_i=0 beats -> no change

Source files
------------

// File: rtl/iob_sipo_deser_pkg.sv
// Shared types and helpers for the iob_sipo_deser deserializer.
package iob_sipo_deser_pkg;

  // Bit-ordering selectors for the MSB_FIRST parameter.
  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

  // What happens to the output slot in a given cycle.
  typedef enum logic [1:0] {
    SLOT_HOLD    = 2'd0,
    SLOT_LOAD    = 2'd1,
    SLOT_DROP    = 2'd2,
    SLOT_CONSUME = 2'd3
  } slot_op_e;

  // Beat counter width: never narrower than one bit, even for single-beat words.
  function automatic int cnt_w_f(input int beats);
    if (beats <= 2) return 1;
    return $clog2(beats);
  endfunction

endpackage

// File: rtl/iob_sipo_deser_if.sv
// Serial-in / word-out bus of the deserializer. Signal suffixes are from the deserializer's view.
interface iob_sipo_deser_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 1
);
  logic              s_valid_i;
  logic [LANES-1:0]  s_i;
  logic              sof_i;
  logic [DATA_W-1:0] p_o;
  logic              p_valid_o;
  logic              p_ready_i;

  // Deserializer side.
  modport slave (
    input  s_valid_i, s_i, sof_i, p_ready_i,
    output p_o, p_valid_o
  );

  // Front end / consumer side.
  modport master (
    output s_valid_i, s_i, sof_i, p_ready_i,
    input  p_o, p_valid_o
  );
endinterface

// File: rtl/iob_sipo_deser_modcnt.sv
// Modulo-MOD beat counter with restart: a restarting beat counts as beat 0 of a new word.
module iob_modcnt #(
  parameter int MOD = 8,
  parameter int W   = 3
) (
  input  logic         clk_i,
  input  logic         cke_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  input  logic         restart_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST       = W'(MOD - 1);
  localparam logic [W-1:0] AFTER_BEAT0 = (MOD == 1) ? '0 : W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count and word-completion flag for the current beat.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = 1'b0;
    if (inc_i) begin
      if (restart_i) begin
        cnt_d  = AFTER_BEAT0;
        wrap_o = (MOD == 1);
      end else if (cnt_q == LAST) begin
        cnt_d  = '0;
        wrap_o = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // Count register, frozen when the clock enable is low.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/iob_sipo_deser.sv
// Serial-to-parallel deserializer: LANES bits per beat into DATA_W-bit words with a
// registered valid/ready output slot, resync on start-of-word and overrun detection.
module iob_sipo_deser
  import iob_sipo_deser_pkg::*;
#(
  parameter int  DATA_W    = 32,
  parameter int  LANES     = 1,
  parameter bit  MSB_FIRST = ORDER_MSB_FIRST,
  localparam int BEATS     = DATA_W / LANES,
  localparam int CNT_W     = cnt_w_f(BEATS)
) (
  input  logic                 clk_i,
  input  logic                 cke_i,
  input  logic                 rst_n_i,
  input  logic                 clr_i,
  iob_sipo_deser_if.slave      bus,
  output logic [CNT_W-1:0]     beat_cnt_o,
  output logic                 overrun_o,
  output logic                 resync_o
);

  if (((DATA_W % LANES) != 0) || (LANES > DATA_W)) begin : g_param_err
    $error("iob_sipo_deser: DATA_W must be a non-zero multiple of LANES");
  end

  logic [DATA_W-1:0] sr_q, sr_d, sr_base;
  logic [DATA_W-1:0] p_q, p_d;
  logic              p_valid_q, p_valid_d;
  logic              overrun_q, overrun_d;
  logic              resync_q, resync_d;
  logic              beat_acc, restart, word_done;
  slot_op_e          slot_op;

  assign beat_acc = cke_i & bus.s_valid_i;
  assign restart  = beat_acc & bus.sof_i;

  iob_modcnt #(
    .MOD (BEATS),
    .W   (CNT_W)
  ) u_modcnt (
    .clk_i     (clk_i),
    .cke_i     (cke_i),
    .rst_n_i   (rst_n_i),
    .inc_i     (beat_acc),
    .restart_i (restart),
    .cnt_o     (beat_cnt_o),
    .wrap_o    (word_done)
  );

  // Shift in the accepted beat; a restart drops whatever partial word was collected.
  always_comb begin
    sr_base = restart ? '0 : sr_q;
    sr_d    = sr_q;
    if (beat_acc) begin
      if (MSB_FIRST) sr_d = (sr_base << LANES) | DATA_W'(bus.s_i);
      else           sr_d = (sr_base >> LANES) | (DATA_W'(bus.s_i) << (DATA_W - LANES));
    end
  end

  // Output slot control: load a finished word if the slot is free or drains this cycle.
  always_comb begin
    slot_op = SLOT_HOLD;
    if (word_done) begin
      slot_op = (!p_valid_q || bus.p_ready_i) ? SLOT_LOAD : SLOT_DROP;
    end else if (p_valid_q && bus.p_ready_i) begin
      slot_op = SLOT_CONSUME;
    end

    p_d       = p_q;
    p_valid_d = p_valid_q;
    case (slot_op)
      SLOT_LOAD: begin
        p_d       = sr_d;
        p_valid_d = 1'b1;
      end
      SLOT_CONSUME: p_valid_d = 1'b0;
      default: ;
    endcase

    // A new event outranks a clear arriving in the same cycle.
    overrun_d = (slot_op == SLOT_DROP) | (overrun_q & ~clr_i);
    resync_d  = (restart & (beat_cnt_o != '0)) | (resync_q & ~clr_i);
  end

  // Datapath and flag registers; everything holds while cke_i is low.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i) begin
        sr_q      <= '0;
        p_q       <= '0;
        p_valid_q <= 1'b0;
        overrun_q <= 1'b0;
        resync_q  <= 1'b0;
      end else begin
        sr_q      <= sr_d;
        p_q       <= p_d;
        p_valid_q <= p_valid_d;
        overrun_q <= overrun_d;
        resync_q  <= resync_d;
      end
    end
  end

  assign bus.p_o       = p_q;
  assign bus.p_valid_o = p_valid_q;
  assign overrun_o     = overrun_q;
  assign resync_o      = resync_q;

endmodule

// File: tb/tb_iob_sipo_deser.sv
// Directed, table-driven bench for iob_sipo_deser: 8-bit MSB-first and LSB-first instances
// share one bit stream; a 32-bit nibble-wide instance covers multi-lane assembly.
module tb_iob_sipo_deser;

  logic clk = 1'b0;
  logic cke, rst_n, clr;
  logic [2:0] cnt8m, cnt8l, cnt32;
  logic ov8m, ov8l, ov32, rs8m, rs8l, rs32;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  iob_sipo_deser_if #(.DATA_W(8),  .LANES(1)) if8m ();
  iob_sipo_deser_if #(.DATA_W(8),  .LANES(1)) if8l ();
  iob_sipo_deser_if #(.DATA_W(32), .LANES(4)) if32 ();

  assign if8l.s_valid_i = if8m.s_valid_i;
  assign if8l.s_i       = if8m.s_i;
  assign if8l.sof_i     = if8m.sof_i;
  assign if8l.p_ready_i = if8m.p_ready_i;

  iob_sipo_deser #(.DATA_W(8), .LANES(1), .MSB_FIRST(1'b1)) u_dut8m (
    .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n), .clr_i(clr), .bus(if8m.slave),
    .beat_cnt_o(cnt8m), .overrun_o(ov8m), .resync_o(rs8m));

  iob_sipo_deser #(.DATA_W(8), .LANES(1), .MSB_FIRST(1'b0)) u_dut8l (
    .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n), .clr_i(clr), .bus(if8l.slave),
    .beat_cnt_o(cnt8l), .overrun_o(ov8l), .resync_o(rs8l));

  iob_sipo_deser #(.DATA_W(32), .LANES(4), .MSB_FIRST(1'b1)) u_dut32 (
    .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n), .clr_i(clr), .bus(if32.slave),
    .beat_cnt_o(cnt32), .overrun_o(ov32), .resync_o(rs32));

  typedef struct {
    logic       v, b, sof, rdy, clr;
    logic [7:0] pm, pl;
    logic       pv;
    logic [2:0] cnt;
    logic       ov, rs;
  } row_t;

  row_t rows[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add_row(input logic v, b, sof, rdy, clr_in,
                         input logic [7:0] pm, pl, input logic pv,
                         input logic [2:0] cnt, input logic ov, rs);
    row_t r;
    r.v = v; r.b = b; r.sof = sof; r.rdy = rdy; r.clr = clr_in;
    r.pm = pm; r.pl = pl; r.pv = pv; r.cnt = cnt; r.ov = ov; r.rs = rs;
    rows.push_back(r);
  endtask

  // Eight beats of value v sent MSB first; expectations are supplied for the
  // beats before completion (*0/_mid) and for the completing beat (*1).
  task automatic add_word(input logic [7:0] v, input logic rdy, rdy_last, clr_last,
                          input logic [7:0] pm0, pl0, input logic pv_mid,
                          input logic [7:0] pm1, pl1, input logic pv1,
                          input logic ov_mid, ov1, rs);
    for (int k = 0; k < 8; k++) begin
      if (k < 7) add_row(1'b1, v[7-k], 1'b0, rdy, 1'b0, pm0, pl0, pv_mid, 3'(k + 1), ov_mid, rs);
      else       add_row(1'b1, v[0], 1'b0, rdy_last, clr_last, pm1, pl1, pv1, 3'd0, ov1, rs);
    end
  endtask

  task automatic drive8(input logic v, b, sof, rdy);
    if8m.s_valid_i = v;
    if8m.s_i       = b;
    if8m.sof_i     = sof;
    if8m.p_ready_i = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cke = 1'b1; rst_n = 1'b0; clr = 1'b0;
    drive8(1'b0, 1'b0, 1'b0, 1'b0);
    if32.s_valid_i = 1'b0; if32.s_i = 4'h0; if32.sof_i = 1'b0; if32.p_ready_i = 1'b0;
    tick(); tick();

    chk("rst p8m",   if8m.p_o, 0);
    chk("rst pv8m",  if8m.p_valid_o, 0);
    chk("rst cnt8m", cnt8m, 0);
    chk("rst ov8m",  ov8m, 0);
    chk("rst rs8m",  rs8m, 0);
    chk("rst p32",   if32.p_o, 0);
    chk("rst pv32",  if32.p_valid_o, 0);
    chk("rst cnt32", cnt32, 0);
    rst_n = 1'b1;

    // A: 0xA5 with ready high; bit-palindrome so both orders give 0xA5.
    add_word(8'hA5, 1, 1, 0, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 1, 0, 0, 0);
    // B: bits 1,1,0,... -> 0xC0 MSB first, 0x03 LSB first; first beat drains A.
    add_word(8'hC0, 1, 1, 0, 8'hA5, 8'hA5, 0, 8'hC0, 8'h03, 1, 0, 0, 0);
    add_row(0, 0, 0, 0, 0, 8'hC0, 8'h03, 1, 3'd0, 0, 0);
    add_row(0, 0, 0, 1, 0, 8'hC0, 8'h03, 0, 3'd0, 0, 0);
    // Overrun: 0x11 fills the slot, 0x22 is dropped, clr then clears.
    add_word(8'h11, 0, 0, 0, 8'hC0, 8'h03, 0, 8'h11, 8'h88, 1, 0, 0, 0);
    add_word(8'h22, 0, 0, 0, 8'h11, 8'h88, 1, 8'h11, 8'h88, 1, 0, 1, 0);
    add_row(0, 0, 0, 0, 1, 8'h11, 8'h88, 1, 3'd0, 0, 0);
    // Drop coinciding with clr: the drop wins.
    add_word(8'h33, 0, 0, 1, 8'h11, 8'h88, 1, 8'h11, 8'h88, 1, 0, 1, 0);
    add_row(0, 0, 0, 1, 1, 8'h11, 8'h88, 0, 3'd0, 0, 0);
    // Back-to-back: slot full, drained on the very cycle the next word completes.
    add_word(8'h5A, 0, 0, 0, 8'h11, 8'h88, 0, 8'h5A, 8'h5A, 1, 0, 0, 0);
    add_word(8'h0F, 0, 1, 0, 8'h5A, 8'h5A, 1, 8'h0F, 8'hF0, 1, 0, 0, 0);
    // Resync: sof at beat 0 is harmless, sof without valid ignored, sof at beat 3 resyncs.
    add_row(1, 1, 1, 1, 0, 8'h0F, 8'hF0, 0, 3'd1, 0, 0);
    add_row(1, 1, 0, 1, 0, 8'h0F, 8'hF0, 0, 3'd2, 0, 0);
    add_row(0, 1, 1, 1, 0, 8'h0F, 8'hF0, 0, 3'd2, 0, 0);
    add_row(1, 1, 0, 1, 0, 8'h0F, 8'hF0, 0, 3'd3, 0, 0);
    add_row(1, 0, 1, 1, 0, 8'h0F, 8'hF0, 0, 3'd1, 0, 1);
    add_row(1, 0, 0, 1, 0, 8'h0F, 8'hF0, 0, 3'd2, 0, 1);
    add_row(1, 1, 0, 1, 0, 8'h0F, 8'hF0, 0, 3'd3, 0, 1);
    add_row(1, 1, 0, 1, 0, 8'h0F, 8'hF0, 0, 3'd4, 0, 1);
    add_row(1, 0, 0, 1, 0, 8'h0F, 8'hF0, 0, 3'd5, 0, 1);
    add_row(1, 1, 0, 1, 0, 8'h0F, 8'hF0, 0, 3'd6, 0, 1);
    add_row(1, 0, 0, 1, 0, 8'h0F, 8'hF0, 0, 3'd7, 0, 1);
    add_row(1, 1, 0, 1, 0, 8'h35, 8'hAC, 1, 3'd0, 0, 1);
    add_row(0, 0, 0, 0, 1, 8'h35, 8'hAC, 1, 3'd0, 0, 0);

    foreach (rows[i]) begin
      drive8(rows[i].v, rows[i].b, rows[i].sof, rows[i].rdy);
      clr = rows[i].clr;
      tick();
      chk($sformatf("row%0d p_msb", i),   if8m.p_o, rows[i].pm);
      chk($sformatf("row%0d p_lsb", i),   if8l.p_o, rows[i].pl);
      chk($sformatf("row%0d pv_msb", i),  if8m.p_valid_o, rows[i].pv);
      chk($sformatf("row%0d pv_lsb", i),  if8l.p_valid_o, rows[i].pv);
      chk($sformatf("row%0d cnt_msb", i), cnt8m, rows[i].cnt);
      chk($sformatf("row%0d cnt_lsb", i), cnt8l, rows[i].cnt);
      chk($sformatf("row%0d ov_msb", i),  ov8m, rows[i].ov);
      chk($sformatf("row%0d ov_lsb", i),  ov8l, rows[i].ov);
      chk($sformatf("row%0d rs_msb", i),  rs8m, rows[i].rs);
      chk($sformatf("row%0d rs_lsb", i),  rs8l, rows[i].rs);
    end
    drive8(0, 0, 0, 0);
    clr = 1'b0;

    // 32-bit, 4 lanes: nibbles 1..8 -> 0x12345678.
    if32.p_ready_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if32.s_valid_i = 1'b1;
      if32.s_i = 4'(k);
      tick();
      if (k == 4) chk("w32 cnt mid", cnt32, 4);
      if (k == 7) chk("w32 pv before last", if32.p_valid_o, 0);
    end
    if32.s_valid_i = 1'b0;
    chk("w32 p",   if32.p_o, 32'h12345678);
    chk("w32 pv",  if32.p_valid_o, 1);
    chk("w32 cnt", cnt32, 0);
    tick();
    chk("w32 pv consumed", if32.p_valid_o, 0);
    chk("w32 p held", if32.p_o, 32'h12345678);
    if32.p_ready_i = 1'b0;

    // Partial word with a pending output, then clock-enable freeze.
    for (int k = 0; k < 3; k++) begin
      drive8(1, 1, 0, 0);
      tick();
    end
    chk("pre-freeze cnt", cnt8m, 3);
    chk("pre-freeze pv",  if8m.p_valid_o, 1);
    cke = 1'b0;
    clr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive8(1, 0, 1, 1);
      tick();
    end
    chk("freeze cnt", cnt8m, 3);
    chk("freeze pv",  if8m.p_valid_o, 1);
    chk("freeze p",   if8m.p_o, 8'h35);
    chk("freeze rs",  rs8m, 0);
    chk("freeze cnt lsb", cnt8l, 3);

    // Reset mid-word with a pending word and a live beat on the bus.
    cke = 1'b1;
    clr = 1'b0;
    rst_n = 1'b0;
    drive8(1, 1, 0, 0);
    tick();
    chk("midrst p",   if8m.p_o, 0);
    chk("midrst pv",  if8m.p_valid_o, 0);
    chk("midrst cnt", cnt8m, 0);
    chk("midrst ov",  ov8m, 0);
    chk("midrst rs",  rs8m, 0);
    chk("midrst p lsb", if8l.p_o, 0);
    chk("midrst p32", if32.p_o, 0);
    rst_n = 1'b1;
    drive8(0, 0, 0, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
